// File: rtl/cnt_checker.sv
// cnt_checker: receive-side checker for a free-running +1 count stream.
// Locks after LOCK_CNT consecutive correct samples, flags and counts
// mismatches while locked, and drops lock after LOSS_CNT consecutive misses.
//
// Ports:
//   clk          - clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   cnt_i        - count word under check (WIDTH bits)
//   valid_i      - cnt_i is sampled only when high
//   clr_i        - synchronous clear of err_cnt_o (and sample_cnt_o)
//   locked_o     - high while in LOCKED state
//   err_o        - one-cycle pulse per mismatching sample while locked
//   err_cnt_o    - saturating count of err_o pulses (ERR_WIDTH bits)
//   sample_cnt_o - saturating count of valid samples while locked
//                  (only when CNT_CHECKER_STATS_EN is defined)
//
// Optional feature macro: CNT_CHECKER_STATS_EN
module cnt_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 3,
  parameter int unsigned ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic                 valid_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_WIDTH-1:0] err_cnt_o
`ifdef CNT_CHECKER_STATS_EN
  ,
  output logic [31:0]          sample_cnt_o
`endif
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LOCK_TGT = CW'(LOCK_CNT);
  localparam logic [CW-1:0] LOSS_TGT = CW'(LOSS_CNT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic [CW-1:0]        match_q, match_d;
  logic [CW-1:0]        miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] err_cnt_q, err_cnt_d;
`ifdef CNT_CHECKER_STATS_EN
  logic [31:0]          sample_cnt_q, sample_cnt_d;
`endif

  logic                 hit;
  logic [WIDTH-1:0]     seed;
  logic [WIDTH-1:0]     step;
  logic [CW-1:0]        match_inc;
  logic [CW-1:0]        miss_inc;

  // Wrap from all-ones to zero falls out of the modulo-2^WIDTH adders.
  assign hit       = (cnt_i == exp_q);
  assign seed      = cnt_i + WIDTH'(1);
  assign step      = exp_q + WIDTH'(1);
  assign match_inc = match_q + CW'(1);
  assign miss_inc  = miss_q + CW'(1);

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef CNT_CHECKER_STATS_EN
    sample_cnt_d = sample_cnt_q;
`endif

    if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          exp_d   = seed;
          match_d = CW'(1);
          miss_d  = '0;
          state_d = (LOCK_TGT <= CW'(1)) ? ST_LOCKED : ST_SYNC;
        end
        ST_SYNC: begin
          if (hit) begin
            exp_d   = step;
            match_d = match_inc;
            if (match_inc >= LOCK_TGT) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            // Reseed on the received word; no error reported before lock.
            exp_d   = seed;
            match_d = CW'(1);
            if (LOCK_TGT <= CW'(1)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            exp_d  = step;
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (miss_inc >= LOSS_TGT) begin
              state_d = ST_SYNC;
              exp_d   = seed;
              match_d = CW'(1);
              miss_d  = '0;
            end else begin
              // Assume a corrupted word, not a skip: keep counting on.
              exp_d  = step;
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Clear beats a same-cycle increment; err_o still pulses.
    if (clr_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
    end

`ifdef CNT_CHECKER_STATS_EN
    if (clr_i) begin
      sample_cnt_d = '0;
    end else if (valid_i && locked_q && (sample_cnt_q != '1)) begin
      sample_cnt_d = sample_cnt_q + 32'(1);
    end
`endif

    locked_d = (state_d == ST_LOCKED);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef CNT_CHECKER_STATS_EN
  // Locked-sample statistics register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign sample_cnt_o = sample_cnt_q;
`endif

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_cnt_checker.sv
// Self-checking bench for cnt_checker: directed scenarios plus randomized
// streams, checked against a sample-level reference model of the checker.
module tb_cnt_checker;

  localparam int unsigned WIDTH = 8;
  localparam int MOD = 256;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] cnt_i;
  logic             valid_i;
  logic             clr_i;

  logic             locked_b, err_b;
  logic [15:0]      ecnt_b;
  logic             locked_s, err_s;
  logic [1:0]       ecnt_s;
`ifdef CNT_CHECKER_STATS_EN
  logic [31:0]      samp_b, samp_s;
`endif

  cnt_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .cnt_i(cnt_i), .valid_i(valid_i), .clr_i(clr_i),
    .locked_o(locked_b), .err_o(err_b), .err_cnt_o(ecnt_b)
`ifdef CNT_CHECKER_STATS_EN
    , .sample_cnt_o(samp_b)
`endif
  );

  cnt_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .cnt_i(cnt_i), .valid_i(valid_i), .clr_i(clr_i),
    .locked_o(locked_s), .err_o(err_s), .err_cnt_o(ecnt_s)
`ifdef CNT_CHECKER_STATS_EN
    , .sample_cnt_o(samp_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: phase 0=waiting, 1=acquiring, 2=locked.
  int  m_phase, m_next, m_run, m_bad;
  bit  m_locked, m_err;
  int  m_ecnt_b, m_ecnt_s;
  longint m_samp;

  function automatic void model_reset();
    m_phase = 0; m_next = 0; m_run = 0; m_bad = 0;
    m_locked = 0; m_err = 0; m_ecnt_b = 0; m_ecnt_s = 0; m_samp = 0;
  endfunction

  function automatic void model_update(input bit v, input int c, input bit clr);
    bit was_locked = m_locked;
    m_err = 0;
    if (v) begin
      if (m_phase == 0) begin
        m_next = (c + 1) % MOD; m_run = 1; m_phase = 1;
      end else if (m_phase == 1) begin
        if (c == m_next) begin
          m_run++; m_next = (m_next + 1) % MOD;
          if (m_run >= 4) begin m_phase = 2; m_bad = 0; end
        end else begin
          m_next = (c + 1) % MOD; m_run = 1;
        end
      end else begin
        if (c == m_next) begin
          m_bad = 0; m_next = (m_next + 1) % MOD;
        end else begin
          m_err = 1; m_bad++;
          if (m_bad >= 3) begin
            m_phase = 1; m_next = (c + 1) % MOD; m_run = 1; m_bad = 0;
          end else begin
            m_next = (m_next + 1) % MOD;
          end
        end
      end
    end
    m_locked = (m_phase == 2);
    if (clr) begin
      m_ecnt_b = 0; m_ecnt_s = 0;
    end else if (m_err) begin
      if (m_ecnt_b < 65535) m_ecnt_b++;
      if (m_ecnt_s < 3) m_ecnt_s++;
    end
    if (clr) m_samp = 0;
    else if (v && was_locked && m_samp < 64'hFFFF_FFFF) m_samp++;
  endfunction

  task automatic step(input bit v, input int c, input bit clr);
    valid_i = v; cnt_i = WIDTH'(c); clr_i = clr;
    @(posedge clk);
    model_update(v, c, clr);
    #1;
    valid_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #4 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_i = 1'b0; cnt_i = '0; clr_i = 1'b0;
    model_reset();
    #12;
    checks++; if (locked_b !== 1'b0) begin fails++; $display("FAIL reset_locked got=%0b exp=0", locked_b); end
    checks++; if (err_b !== 1'b0) begin fails++; $display("FAIL reset_err got=%0b exp=0", err_b); end
    checks++; if (ecnt_b !== 16'd0) begin fails++; $display("FAIL reset_errcnt got=%0d exp=0", ecnt_b); end
    #4 reset = 1'b1;
  endtask

  task automatic test_lock();
    int seq[4] = '{10, 11, 12, 13};
    do_reset();
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      checks++;
      if (locked_b !== (i == 3)) begin
        fails++; $display("FAIL lock_locked idx=%0d got=%0b exp=%0b", i, locked_b, (i == 3));
      end
    end
    checks++; if (ecnt_b !== 16'd0) begin fails++; $display("FAIL lock_errcnt got=%0d exp=0", ecnt_b); end
  endtask

  task automatic test_wrap();
    int seq[8] = '{250, 251, 252, 253, 254, 255, 0, 1};
    do_reset();
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      if (i >= 4) begin
        checks++; if (err_b !== 1'b0) begin fails++; $display("FAIL wrap_err idx=%0d got=%0b exp=0", i, err_b); end
        checks++; if (locked_b !== 1'b1) begin fails++; $display("FAIL wrap_locked idx=%0d got=%0b exp=1", i, locked_b); end
      end
    end
  endtask

  task automatic test_glitch();
    int seq[9] = '{16, 17, 18, 19, 20, 21, 99, 23, 24};
    do_reset();
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      if (i >= 4) begin
        checks++; if (err_b !== (i == 6)) begin fails++; $display("FAIL glitch_err idx=%0d got=%0b exp=%0b", i, err_b, (i == 6)); end
        checks++; if (locked_b !== 1'b1) begin fails++; $display("FAIL glitch_locked idx=%0d got=%0b exp=1", i, locked_b); end
      end
    end
    checks++; if (ecnt_b !== 16'd1) begin fails++; $display("FAIL glitch_errcnt got=%0d exp=1", ecnt_b); end
  endtask

  task automatic test_loss_relock();
    int seq[11] = '{40, 41, 42, 43, 44, 50, 60, 70, 71, 72, 73};
    bit exp_lock[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    bit exp_err[11]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    do_reset();
    foreach (seq[i]) begin
      step(1, seq[i], 0);
      checks++; if (locked_b !== exp_lock[i]) begin fails++; $display("FAIL loss_locked idx=%0d got=%0b exp=%0b", i, locked_b, exp_lock[i]); end
      checks++; if (err_b !== exp_err[i]) begin fails++; $display("FAIL loss_err idx=%0d got=%0b exp=%0b", i, err_b, exp_err[i]); end
      if (i == 7) begin
        checks++; if (ecnt_b !== 16'd3) begin fails++; $display("FAIL loss_errcnt got=%0d exp=3", ecnt_b); end
      end
    end
  endtask

  task automatic test_sat_clear();
    int e = 104;
    do_reset();
    for (int k = 100; k < 104; k++) step(1, k, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      checks++; if (err_s !== 1'b1) begin fails++; $display("FAIL sat_err k=%0d got=%0b exp=1", k, err_s); end
      step(1, e + 1, 0);
      e += 2;
    end
    checks++; if (ecnt_s !== 2'd3) begin fails++; $display("FAIL sat_errcnt got=%0d exp=3", ecnt_s); end
    checks++; if (ecnt_b !== 16'd5) begin fails++; $display("FAIL sat_errcnt_wide got=%0d exp=5", ecnt_b); end
    checks++; if (locked_s !== 1'b1) begin fails++; $display("FAIL sat_locked got=%0b exp=1", locked_s); end
    step(1, 0, 1);
    checks++; if (err_s !== 1'b1) begin fails++; $display("FAIL clr_err got=%0b exp=1", err_s); end
    checks++; if (ecnt_s !== 2'd0) begin fails++; $display("FAIL clr_errcnt got=%0d exp=0", ecnt_s); end
    checks++; if (ecnt_b !== 16'd0) begin fails++; $display("FAIL clr_errcnt_wide got=%0d exp=0", ecnt_b); end
  endtask

  task automatic test_async_reset();
    int seq[6] = '{180, 181, 182, 183, 184, 7};
    do_reset();
    foreach (seq[i]) step(1, seq[i], 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (locked_b !== 1'b0) begin fails++; $display("FAIL arst_locked got=%0b exp=0", locked_b); end
    checks++; if (ecnt_b !== 16'd0) begin fails++; $display("FAIL arst_errcnt got=%0d exp=0", ecnt_b); end
    #10 reset = 1'b1;
    model_reset();
    for (int k = 200; k < 204; k++) begin
      step(1, k, 0);
      checks++; if (err_b !== 1'b0) begin fails++; $display("FAIL arst_err val=%0d got=%0b exp=0", k, err_b); end
      checks++; if (locked_b !== (k == 203)) begin fails++; $display("FAIL arst_relock val=%0d got=%0b exp=%0b", k, locked_b, (k == 203)); end
    end
  endtask

  task automatic test_random();
    int tx;
    int w;
    bit v, clr;
    do_reset();
    tx = int'($urandom_range(0, 255));
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = tx;
      if (((i / 300) % 2) == 1) begin
        if ($urandom_range(0, 2) == 0) w = int'($urandom_range(0, 255));
      end else begin
        if ($urandom_range(0, 11) == 0) w = int'($urandom_range(0, 255));
      end
      if (v) tx = (tx + 1) % MOD;
      if ($urandom_range(0, 199) == 0) tx = int'($urandom_range(0, 255));
      clr = ($urandom_range(0, 39) == 0);
      step(v, w, clr);
      checks++; if (locked_b !== m_locked) begin fails++; $display("FAIL rnd_locked cyc=%0d got=%0b exp=%0b", i, locked_b, m_locked); end
      checks++; if (err_b !== m_err) begin fails++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", i, err_b, m_err); end
      checks++; if (ecnt_b !== 16'(m_ecnt_b)) begin fails++; $display("FAIL rnd_errcnt cyc=%0d got=%0d exp=%0d", i, ecnt_b, m_ecnt_b); end
      checks++; if (ecnt_s !== 2'(m_ecnt_s)) begin fails++; $display("FAIL rnd_errcnt_sat cyc=%0d got=%0d exp=%0d", i, ecnt_s, m_ecnt_s); end
      checks++; if ((locked_s !== m_locked) || (err_s !== m_err)) begin
        fails++; $display("FAIL rnd_sat_flags cyc=%0d got=%0b%0b exp=%0b%0b", i, locked_s, err_s, m_locked, m_err);
      end
`ifdef CNT_CHECKER_STATS_EN
      checks++; if (samp_b !== 32'(m_samp)) begin fails++; $display("FAIL rnd_samples cyc=%0d got=%0d exp=%0d", i, samp_b, m_samp); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_glitch();
    test_loss_relock();
    test_sat_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
